// File: rtl/conv_encoder_pkg.sv
// Shared trellis definition for the convolutional encoder and its matching decoder.
// Holds code geometry (K_IN/N_OUT/MEM), frame sizing, generator masks and FSM state type.
// Ports: none (package).
package conv_encoder_pkg;

   localparam int CONV_K_IN       = 2;
   localparam int CONV_N_OUT      = 3;
   localparam int CONV_MEM        = 2;
   localparam int TRACEBACK_DEPTH = 16;
   localparam int FRAME_STEPS     = TRACEBACK_DEPTH;

   localparam int CONV_STATE_W = CONV_K_IN * CONV_MEM;
   localparam int CONV_REG_W   = CONV_K_IN * (CONV_MEM + 1);
   localparam int FRAME_BITS   = FRAME_STEPS * CONV_K_IN;
   localparam int FRAME_SYMS   = FRAME_STEPS + CONV_MEM;
   localparam int CNT_W        = $clog2(FRAME_SYMS);

   // GEN[j] drives symbol bit j. Packed-array concatenation puts the
   // leftmost mask at the highest index, so GEN[0] = 6'b110101.
   typedef logic [CONV_N_OUT-1:0][CONV_REG_W-1:0] gen_t;
   localparam gen_t CONV_GEN = {6'b011011, 6'b101110, 6'b110101};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ENC  = 2'd1,
      TAIL = 2'd2
   } enc_state_t;

endpackage

// File: rtl/conv_enc_sym.sv
// Trellis output function: maps current input u and shift-register state s to one coded symbol.
// Latency: purely combinational. Backpressure: none (no state, no handshake).
// Ports: u (K_IN input bits), s (K_IN*MEM state bits, newest input in MSBs), sym (N_OUT coded bits).
module conv_enc_sym
   import conv_encoder_pkg::*;
#(
   parameter gen_t GEN = CONV_GEN
) (
   input  logic [CONV_K_IN-1:0]    u,
   input  logic [CONV_STATE_W-1:0] s,
   output logic [CONV_N_OUT-1:0]   sym
);

   logic [CONV_REG_W-1:0] r;

   assign r = {u, s};

   always_comb begin
      sym = '0;
      for (int j = 0; j < CONV_N_OUT; j++) begin
         sym[j] = ^(r & GEN[j]);
      end
   end

endmodule

// File: rtl/conv_encoder.sv
// Frame convolutional encoder: loads FRAME_STEPS input pairs, emits data symbols then MEM zero-tail symbols.
// Latency: first symbol valid the cycle after an accepted i_start; one symbol per cycle with i_sym_ready high.
// Backpressure: o_sym/o_sym_valid are registered and hold while i_sym_ready=0; state advances only on handshake.
// Ports: clk, rst (sync, active-high); i_start/i_data frame load gated by o_ready;
//        o_sym/o_sym_valid/i_sym_ready symbol handshake; o_done pulses after the last tail symbol.
module conv_encoder
   import conv_encoder_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [FRAME_BITS-1:0] i_data,
   output logic                  o_ready,
   output logic [CONV_N_OUT-1:0] o_sym,
   output logic                  o_sym_valid,
   input  logic                  i_sym_ready,
   output logic                  o_done
);

   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_STEPS - 1);
   localparam logic [CNT_W-1:0] LAST_SYM  = CNT_W'(FRAME_SYMS - 1);

   enc_state_t              st;
   logic [FRAME_BITS-1:0]   data_q;
   logic [CONV_STATE_W-1:0] enc_s;
   logic [CNT_W-1:0]        cnt;

   logic                    hs;
   logic [CONV_STATE_W-1:0] s_adv;
   logic [CONV_K_IN-1:0]    sym_u;
   logic [CONV_STATE_W-1:0] sym_s;
   logic [CONV_N_OUT-1:0]   sym_next;
   logic                    unused_state_lsbs;

   assign hs = o_sym_valid & i_sym_ready;

   // data_q[K-1:0] always holds the input of the symbol currently on o_sym;
   // s_adv is the state after that step is handshaked.
   assign s_adv = {data_q[CONV_K_IN-1:0], enc_s[CONV_STATE_W-1:CONV_K_IN]};

   // The registered symbol is one step ahead of the state: at load time the
   // first step is encoded from i_data with a zero state, afterwards the next
   // step is encoded from the advanced state. Zeros shift into data_q, which
   // supplies the all-zero tail inputs for free.
   always_comb begin
      sym_u = data_q[2*CONV_K_IN-1:CONV_K_IN];
      sym_s = s_adv;
      if (st == IDLE) begin
         sym_u = i_data[CONV_K_IN-1:0];
         sym_s = '0;
      end
   end

   // The oldest input pair only contributes to the symbol already registered,
   // so it is never read again before being shifted out.
   assign unused_state_lsbs = ^enc_s[CONV_K_IN-1:0];

   conv_enc_sym #(
      .GEN (CONV_GEN)
   ) u_sym (
      .u   (sym_u),
      .s   (sym_s),
      .sym (sym_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         st          <= IDLE;
         o_ready     <= 1'b1;
         o_sym       <= '0;
         o_sym_valid <= 1'b0;
         o_done      <= 1'b0;
         enc_s       <= '0;
         cnt         <= '0;
         data_q      <= '0;
      end else begin
         o_done <= 1'b0;
         case (st)
            IDLE: begin
               if (i_start) begin
                  data_q      <= i_data;
                  enc_s       <= '0;
                  cnt         <= '0;
                  o_sym       <= sym_next;
                  o_sym_valid <= 1'b1;
                  o_ready     <= 1'b0;
                  st          <= ENC;
               end
            end
            ENC, TAIL: begin
               if (hs) begin
                  enc_s  <= s_adv;
                  data_q <= {{CONV_K_IN{1'b0}}, data_q[FRAME_BITS-1:CONV_K_IN]};
                  cnt    <= cnt + 1'b1;
                  if (st == TAIL && cnt == LAST_SYM) begin
                     st          <= IDLE;
                     o_sym       <= '0;
                     o_sym_valid <= 1'b0;
                     o_ready     <= 1'b1;
                     o_done      <= 1'b1;
                  end else begin
                     o_sym <= sym_next;
                     if (st == ENC && cnt == LAST_DATA) begin
                        st <= TAIL;
                     end
                  end
               end
            end
            default: begin
               st <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_encoder.sv
module tb_conv_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic [31:0] i_data;
   logic        o_ready;
   logic [2:0]  o_sym;
   logic        o_sym_valid;
   logic        i_sym_ready;
   logic        o_done;

   int checks   = 0;
   int failures = 0;

   logic [2:0] got     [0:63];
   logic [2:0] exp_sym [0:17];
   int         got_n;
   int         got_cycles;
   int         stall_bad;
   bit         got_done;
   bit         start_ok;

   conv_encoder dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (i_start),
      .i_data      (i_data),
      .o_ready     (o_ready),
      .o_sym       (o_sym),
      .o_sym_valid (o_sym_valid),
      .i_sym_ready (i_sym_ready),
      .o_done      (o_done)
   );

   always #5 clk = ~clk;

   // Expected frame: all zero except three hand-computed symbols at base..base+2.
   task automatic set_exp(input logic [2:0] a0, input logic [2:0] a1,
                          input logic [2:0] a2, input int base);
      for (int i = 0; i < 18; i++) exp_sym[i] = 3'b000;
      exp_sym[base]     = a0;
      exp_sym[base + 1] = a1;
      exp_sym[base + 2] = a2;
   endtask

   // Starts a frame from the current (post-edge) cycle and collects accepted
   // symbols until o_done or a cycle budget runs out. bp selects the 1,0,0
   // ready pattern; junk pulses i_start mid-frame with unrelated data.
   task automatic run_frame(input logic [31:0] data, input bit bp, input bit junk);
      bit         prev_stall;
      logic [2:0] prev_sym;
      for (int i = 0; i < 64; i++) got[i] = 3'bxxx;
      got_n      = 0;
      got_cycles = 0;
      stall_bad  = 0;
      got_done   = 0;
      start_ok   = o_ready;
      i_data     = data;
      i_start    = 1'b1;
      @(posedge clk); #1;
      i_start    = 1'b0;
      i_data     = 32'hA5A5_5A5A;
      prev_stall = 0;
      prev_sym   = 3'b000;
      for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
         i_sym_ready = bp ? (cyc % 3 == 0) : 1'b1;
         i_start     = junk && (cyc == 4);
         if (junk && cyc == 4) i_data = 32'hFFFF_FFFF;
         if (o_done === 1'b1) begin
            got_done = 1;
         end else begin
            if (prev_stall && (o_sym_valid !== 1'b1 || o_sym !== prev_sym)) stall_bad++;
            if (o_sym_valid === 1'b1 && i_sym_ready) begin
               if (got_n < 64) got[got_n] = o_sym;
               got_n++;
            end
            prev_stall = (o_sym_valid === 1'b1) && !i_sym_ready;
            prev_sym   = o_sym;
            got_cycles++;
            @(posedge clk); #1;
         end
      end
      i_start     = 1'b0;
      i_sym_ready = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", o_ready); end
      checks++; if (o_sym_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", o_sym_valid); end
      checks++; if (o_sym !== 3'b000) begin failures++; $display("FAIL reset_sym got %b want 000", o_sym); end
      checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", o_done); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_zero_frame;
      set_exp(3'b000, 3'b000, 3'b000, 0);
      run_frame(32'h0000_0000, 0, 0);
      checks++; if (!got_done) begin failures++; $display("FAIL zero_done_seen got 0 want 1"); end
      checks++; if (got_n !== 18) begin failures++; $display("FAIL zero_count got %0d want 18", got_n); end
      checks++; if (got_cycles !== 18) begin failures++; $display("FAIL zero_no_bubbles cycles %0d want 18", got_cycles); end
      for (int i = 0; i < 18; i++) begin
         checks++;
         if (got[i] !== exp_sym[i]) begin failures++; $display("FAIL zero_sym[%0d] got %b want %b", i, got[i], exp_sym[i]); end
      end
      checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL zero_done_ready got %b want 1", o_ready); end
      checks++; if (o_sym_valid !== 1'b0 || o_sym !== 3'b000) begin failures++; $display("FAIL zero_done_out valid %b sym %b want 0 000", o_sym_valid, o_sym); end
      @(posedge clk); #1;
      checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL zero_done_pulse got %b want 0", o_done); end
   endtask

   task automatic test_patterns;
      logic [31:0] pat_data [0:3];
      logic [2:0]  pat_a    [0:3][0:2];
      int          pat_base [0:3];
      pat_data[0] = 32'h0000_0001; pat_a[0][0] = 3'b101; pat_a[0][1] = 3'b011; pat_a[0][2] = 3'b101; pat_base[0] = 0;
      pat_data[1] = 32'h0000_0002; pat_a[1][0] = 3'b011; pat_a[1][1] = 3'b110; pat_a[1][2] = 3'b110; pat_base[1] = 0;
      pat_data[2] = 32'h0000_0003; pat_a[2][0] = 3'b110; pat_a[2][1] = 3'b101; pat_a[2][2] = 3'b011; pat_base[2] = 0;
      pat_data[3] = 32'h4000_0000; pat_a[3][0] = 3'b101; pat_a[3][1] = 3'b011; pat_a[3][2] = 3'b101; pat_base[3] = 15;
      for (int p = 0; p < 4; p++) begin
         set_exp(pat_a[p][0], pat_a[p][1], pat_a[p][2], pat_base[p]);
         @(posedge clk); #1;
         run_frame(pat_data[p], 0, 0);
         checks++; if (got_n !== 18 || !got_done) begin failures++; $display("FAIL pat%0d_count got %0d done %0d want 18 1", p, got_n, got_done); end
         for (int i = 0; i < 18; i++) begin
            checks++;
            if (got[i] !== exp_sym[i]) begin failures++; $display("FAIL pat%0d_sym[%0d] got %b want %b", p, i, got[i], exp_sym[i]); end
         end
      end
   endtask

   task automatic test_backpressure;
      set_exp(3'b101, 3'b011, 3'b101, 0);
      @(posedge clk); #1;
      run_frame(32'h0000_0001, 1, 0);
      checks++; if (got_n !== 18 || !got_done) begin failures++; $display("FAIL bp_count got %0d done %0d want 18 1", got_n, got_done); end
      checks++; if (stall_bad !== 0) begin failures++; $display("FAIL bp_stall_stable got %0d changes want 0", stall_bad); end
      for (int i = 0; i < 18; i++) begin
         checks++;
         if (got[i] !== exp_sym[i]) begin failures++; $display("FAIL bp_sym[%0d] got %b want %b", i, got[i], exp_sym[i]); end
      end
   endtask

   task automatic test_reset_mid_frame;
      @(posedge clk); #1;
      i_sym_ready = 1'b1;
      i_data      = 32'h0000_0001;
      i_start     = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++; if (o_sym_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid got %b want 1", o_sym_valid); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (o_sym_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got %b want 0", o_sym_valid); end
      checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got %b want 1", o_ready); end
      checks++; if (o_sym !== 3'b000) begin failures++; $display("FAIL midrst_sym got %b want 000", o_sym); end
      set_exp(3'b101, 3'b011, 3'b101, 0);
      run_frame(32'h0000_0001, 0, 0);
      checks++; if (got_n !== 18 || !got_done) begin failures++; $display("FAIL midrst_count got %0d done %0d want 18 1", got_n, got_done); end
      for (int i = 0; i < 18; i++) begin
         checks++;
         if (got[i] !== exp_sym[i]) begin failures++; $display("FAIL midrst_sym[%0d] got %b want %b", i, got[i], exp_sym[i]); end
      end
   endtask

   task automatic test_ignored_start;
      set_exp(3'b011, 3'b110, 3'b110, 0);
      @(posedge clk); #1;
      run_frame(32'h0000_0002, 0, 1);
      checks++; if (got_n !== 18 || !got_done) begin failures++; $display("FAIL ignstart_count got %0d done %0d want 18 1", got_n, got_done); end
      for (int i = 0; i < 18; i++) begin
         checks++;
         if (got[i] !== exp_sym[i]) begin failures++; $display("FAIL ignstart_sym[%0d] got %b want %b", i, got[i], exp_sym[i]); end
      end
      // Returning to idle must not leave a latched start behind.
      @(posedge clk); #1;
      checks++; if (o_sym_valid !== 1'b0 || o_ready !== 1'b1) begin failures++; $display("FAIL ignstart_idle valid %b ready %b want 0 1", o_sym_valid, o_ready); end
   endtask

   task automatic test_back_to_back;
      @(posedge clk); #1;
      run_frame(32'h0000_0003, 0, 0);
      checks++; if (!got_done) begin failures++; $display("FAIL b2b_first_done got 0 want 1"); end
      // Start the second frame in the o_done cycle itself.
      set_exp(3'b101, 3'b011, 3'b101, 15);
      run_frame(32'h4000_0000, 0, 0);
      checks++; if (start_ok !== 1'b1) begin failures++; $display("FAIL b2b_ready_in_done got %b want 1", start_ok); end
      checks++; if (got_n !== 18 || !got_done) begin failures++; $display("FAIL b2b_count got %0d done %0d want 18 1", got_n, got_done); end
      for (int i = 0; i < 18; i++) begin
         checks++;
         if (got[i] !== exp_sym[i]) begin failures++; $display("FAIL b2b_sym[%0d] got %b want %b", i, got[i], exp_sym[i]); end
      end
   endtask

   initial begin
      rst         = 1'b1;
      i_start     = 1'b0;
      i_data      = 32'h0;
      i_sym_ready = 1'b1;
      test_reset;
      test_zero_frame;
      test_patterns;
      test_backpressure;
      test_reset_mid_frame;
      test_ignored_start;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
